// File: rtl/vx_gpu_pkg.sv
// Shared types and helpers for the dcache port arbiter: output-register state enum,
// select-field width helper and perf counter width.
package vx_gpu_pkg;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

  localparam int PERF_CTR_BITS = 32;

  // Width of the requester-index field appended to tags; never zero so a single
  // requester still carries a 1-bit index.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_grant.sv
// Round-robin grant: picks the first requesting index after the last granted one,
// wrapping to 0. The pointer only moves on a grant.
module vx_rr_grant #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] last_idx;
  logic [N-1:0]     upper_mask;
  logic [N-1:0]     req_upper;
  logic [N-1:0]     pick_from;

  // Requests above the last grant win; otherwise wrap around to the lowest one.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N; i++) upper_mask[i] = (IDX_W'(i) > last_idx);
  end

  assign req_upper   = req & upper_mask;
  assign pick_from   = (|req_upper) ? req_upper : req;
  assign grant_valid = enable && (|req);

  always_comb begin
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick_from[i]) grant_idx = IDX_W'(i);
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) grant[i] = grant_valid && (grant_idx == IDX_W'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_idx <= IDX_W'(N - 1);
    else if (grant_valid) last_idx <= grant_idx;
  end

endmodule

// File: rtl/vx_dcache_port_arb.sv
// Funnels NUM_REQS requesters onto one dcache request port with round-robin grants and
// per-requester read limits, and routes responses back by tag index. DCACHE_PORT_ARB_PERF_EN adds a stall counter.
module vx_dcache_port_arb
  import vx_gpu_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_SIZE   = 4,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 8,
  localparam int SEL_BITS   = sel_bits(NUM_REQS),
  localparam int DW         = 8 * DATA_SIZE
) (
  input  logic                                     clk,
  input  logic                                     reset,
  // Every channel: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and a sender holds valid and payload until the transfer.
  input  logic [NUM_REQS-1:0]                      req_valid_in,
  output logic [NUM_REQS-1:0]                      req_ready_in,
  input  logic [NUM_REQS-1:0]                      req_rw_in,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]      req_addr_in,
  input  logic [NUM_REQS-1:0][DW-1:0]              req_data_in,
  input  logic [NUM_REQS-1:0][DATA_SIZE-1:0]       req_byteen_in,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]       req_tag_in,
  output logic                                     req_valid_out,
  input  logic                                     req_ready_out,
  output logic                                     req_rw_out,
  output logic [ADDR_WIDTH-1:0]                    req_addr_out,
  output logic [DW-1:0]                            req_data_out,
  output logic [DATA_SIZE-1:0]                     req_byteen_out,
  output logic [TAG_WIDTH+SEL_BITS-1:0]            req_tag_out,
  input  logic                                     rsp_valid_in,
  output logic                                     rsp_ready_in,
  input  logic [DW-1:0]                            rsp_data_in,
  input  logic [TAG_WIDTH+SEL_BITS-1:0]            rsp_tag_in,
  output logic [NUM_REQS-1:0]                      rsp_valid_out,
  input  logic [NUM_REQS-1:0]                      rsp_ready_out,
  output logic [NUM_REQS-1:0][DW-1:0]              rsp_data_out,
  output logic [NUM_REQS-1:0][TAG_WIDTH-1:0]       rsp_tag_out,
  output arb_state_e                               state_dbg
`ifdef DCACHE_PORT_ARB_PERF_EN
  , output logic [PERF_CTR_BITS-1:0]               perf_stall_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  arb_state_e                      state, state_n;
  logic [NUM_REQS-1:0][CNT_W-1:0]  pend_cnt;
  logic [NUM_REQS-1:0]             eligible, grant, rsp_fire, read_grant;
  logic [SEL_BITS-1:0]             grant_idx, rsp_idx;
  logic                            grant_valid, can_grant;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++)
      eligible[i] = req_valid_in[i] && (req_rw_in[i] || (pend_cnt[i] < CNT_W'(MAX_PENDING)));
  end

  // Refill in the same cycle the register drains, so back-to-back grants lose no cycle.
  assign can_grant = (state == ARB_EMPTY) || req_ready_out;

  vx_rr_grant #(.N(NUM_REQS), .IDX_W(SEL_BITS)) rr_grant (
    .clk         (clk),
    .reset       (reset),
    .req         (eligible),
    .enable      (can_grant && !reset),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready_in  = grant;
  assign req_valid_out = (state == ARB_FULL);
  assign state_dbg     = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_EMPTY;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ARB_EMPTY: if (grant_valid) state_n = ARB_FULL;
      ARB_FULL:  if (req_ready_out && !grant_valid) state_n = ARB_EMPTY;
      default:   state_n = ARB_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_rw_out     <= 1'b0;
      req_addr_out   <= '0;
      req_data_out   <= '0;
      req_byteen_out <= '0;
      req_tag_out    <= '0;
    end else if (grant_valid) begin
      req_rw_out     <= req_rw_in[grant_idx];
      req_addr_out   <= req_addr_in[grant_idx];
      req_data_out   <= req_data_in[grant_idx];
      req_byteen_out <= req_byteen_in[grant_idx];
      req_tag_out    <= {req_tag_in[grant_idx], grant_idx};
    end
  end

  // An index matching no requester leaves rsp_ready_in high so the response drains silently.
  assign rsp_idx = rsp_tag_in[SEL_BITS-1:0];

  always_comb begin
    rsp_valid_out = '0;
    rsp_ready_in  = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rsp_idx == SEL_BITS'(i)) begin
        rsp_valid_out[i] = rsp_valid_in;
        rsp_ready_in     = rsp_ready_out[i];
      end
    end
  end

  always_comb begin
    rsp_data_out = '0;
    rsp_tag_out  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_data_out[i] = rsp_data_in;
      rsp_tag_out[i]  = rsp_tag_in[SEL_BITS +: TAG_WIDTH];
    end
  end

  assign rsp_fire   = rsp_valid_out & rsp_ready_out;
  assign read_grant = grant & ~req_rw_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (read_grant[i] && !rsp_fire[i])      pend_cnt[i] <= pend_cnt[i] + CNT_W'(1);
        else if (rsp_fire[i] && !read_grant[i]) pend_cnt[i] <= pend_cnt[i] - CNT_W'(1);
      end
    end
  end

`ifdef DCACHE_PORT_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_stall_cycles <= '0;
    else if ((|req_valid_in) && !grant_valid) perf_stall_cycles <= perf_stall_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_vx_dcache_port_arb.sv
// Bench for vx_dcache_port_arb: directed scenarios plus a randomized run against a
// rule-level reference model. Perf scenario needs DCACHE_PORT_ARB_PERF_EN.
module tb_vx_dcache_port_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TW = 8;
  localparam int MP = 8;
  localparam int SB = 2;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]          req_valid_in, req_ready_in, req_rw_in;
  logic [N-1:0][AW-1:0]  req_addr_in;
  logic [N-1:0][DW-1:0]  req_data_in;
  logic [N-1:0][BW-1:0]  req_byteen_in;
  logic [N-1:0][TW-1:0]  req_tag_in;
  logic                  req_valid_out, req_ready_out, req_rw_out;
  logic [AW-1:0]         req_addr_out;
  logic [DW-1:0]         req_data_out;
  logic [BW-1:0]         req_byteen_out;
  logic [TW+SB-1:0]      req_tag_out;
  logic                  rsp_valid_in, rsp_ready_in;
  logic [DW-1:0]         rsp_data_in;
  logic [TW+SB-1:0]      rsp_tag_in;
  logic [N-1:0]          rsp_valid_out, rsp_ready_out;
  logic [N-1:0][DW-1:0]  rsp_data_out;
  logic [N-1:0][TW-1:0]  rsp_tag_out;
  logic                  state_dbg;
`ifdef DCACHE_PORT_ARB_PERF_EN
  logic [31:0]           perf_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vx_dcache_port_arb dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_ready_in(req_ready_in), .req_rw_in(req_rw_in),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_byteen_in(req_byteen_in),
    .req_tag_in(req_tag_in), .req_valid_out(req_valid_out), .req_ready_out(req_ready_out),
    .req_rw_out(req_rw_out), .req_addr_out(req_addr_out), .req_data_out(req_data_out),
    .req_byteen_out(req_byteen_out), .req_tag_out(req_tag_out),
    .rsp_valid_in(rsp_valid_in), .rsp_ready_in(rsp_ready_in), .rsp_data_in(rsp_data_in),
    .rsp_tag_in(rsp_tag_in), .rsp_valid_out(rsp_valid_out), .rsp_ready_out(rsp_ready_out),
    .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out), .state_dbg(state_dbg)
`ifdef DCACHE_PORT_ARB_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  // ---------------- clock / reset helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_in  = '0;
    req_rw_in     = '0;
    req_addr_in   = '0;
    req_data_in   = '0;
    req_byteen_in = '0;
    req_tag_in    = '0;
    req_ready_out = 1'b0;
    rsp_valid_in  = 1'b0;
    rsp_data_in   = '0;
    rsp_tag_in    = '0;
    rsp_ready_out = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic rand_payload(input int i);
    req_addr_in[i]   = $urandom;
    req_data_in[i]   = $urandom;
    req_byteen_in[i] = 4'($urandom_range(0, 15));
    req_tag_in[i]    = 8'($urandom_range(0, 255));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    req_valid_in = '1;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++;
      if (req_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out: got %b want 0", req_valid_out); end
      total++;
      if (req_ready_in !== 4'b0000) begin bad++; $display("FAIL reset_ready_in: got %b want 0000", req_ready_in); end
      total++;
      if (state_dbg !== 1'b0) begin bad++; $display("FAIL reset_state: got %b want 0", state_dbg); end
      step();
    end
    reset = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] e;
    do_reset();
    req_valid_in  = '1;
    req_ready_out = 1'b1;
    for (int i = 0; i < N; i++) rand_payload(i);
    for (int k = 0; k < 5; k++) begin
      settle();
      e = 4'b0001 << (k % 4);
      total++;
      if (req_ready_in !== e) begin bad++; $display("FAIL rr_grant k=%0d: got %b want %b", k, req_ready_in, e); end
      step();
      total++;
      if (req_tag_out[1:0] !== 2'(k % 4)) begin bad++; $display("FAIL rr_tag_idx k=%0d: got %0d want %0d", k, req_tag_out[1:0], k % 4); end
      total++;
      if (req_tag_out[9:2] !== req_tag_in[k % 4] || req_addr_out !== req_addr_in[k % 4] || req_valid_out !== 1'b1) begin
        bad++; $display("FAIL rr_payload k=%0d: got tag %h addr %h want tag %h addr %h", k, req_tag_out[9:2], req_addr_out, req_tag_in[k % 4], req_addr_in[k % 4]);
      end
    end
  endtask

  task automatic test_pending_limit();
    logic [31:0] d;
    do_reset();
    req_valid_in[1] = 1'b1;
    req_ready_out   = 1'b1;
    for (int k = 0; k < MP; k++) begin
      rand_payload(1);
      settle();
      total++;
      if (req_ready_in !== 4'b0010) begin bad++; $display("FAIL limit_grant k=%0d: got %b want 0010", k, req_ready_in); end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      settle();
      total++;
      if (req_ready_in !== 4'b0000) begin bad++; $display("FAIL limit_held k=%0d: got %b want 0000", k, req_ready_in); end
      step();
    end
    d = $urandom;
    rsp_valid_in  = 1'b1;
    rsp_tag_in    = {8'h5A, 2'd1};
    rsp_data_in   = d;
    rsp_ready_out = 4'b1101;
    settle();
    total++;
    if (rsp_ready_in !== 1'b0) begin bad++; $display("FAIL rsp_ready_route: got %b want 0", rsp_ready_in); end
    step();
    rsp_ready_out = 4'b0010;
    settle();
    total++;
    if (rsp_valid_out !== 4'b0010 || rsp_ready_in !== 1'b1) begin bad++; $display("FAIL rsp_route: got v=%b r=%b want v=0010 r=1", rsp_valid_out, rsp_ready_in); end
    total++;
    if (rsp_data_out[1] !== d || rsp_tag_out[1] !== 8'h5A) begin bad++; $display("FAIL rsp_payload: got %h/%h want %h/5a", rsp_data_out[1], rsp_tag_out[1], d); end
    total++;
    if (req_ready_in !== 4'b0000) begin bad++; $display("FAIL limit_same_cycle: got %b want 0000", req_ready_in); end
    step();
    rsp_valid_in  = 1'b0;
    rsp_ready_out = '0;
    settle();
    total++;
    if (req_ready_in !== 4'b0010) begin bad++; $display("FAIL limit_release: got %b want 0010", req_ready_in); end
    step();
  endtask

  task automatic test_stall();
    logic [78:0] held;
    do_reset();
    req_valid_in[3] = 1'b1;
    req_rw_in[3]    = 1'b1;
    rand_payload(3);
    settle();
    total++;
    if (req_ready_in !== 4'b1000) begin bad++; $display("FAIL stall_first: got %b want 1000", req_ready_in); end
    held = {1'b1, req_addr_in[3], req_data_in[3], req_byteen_in[3], req_tag_in[3], 2'd3};
    step();
    req_valid_in = '1;
    req_rw_in    = '0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) rand_payload(i);
      settle();
      total++;
      if (req_ready_in !== 4'b0000 || req_valid_out !== 1'b1) begin bad++; $display("FAIL stall_hs c=%0d: got rdy=%b v=%b want 0000/1", c, req_ready_in, req_valid_out); end
      total++;
      if ({req_rw_out, req_addr_out, req_data_out, req_byteen_out, req_tag_out} !== held) begin
        bad++; $display("FAIL stall_payload c=%0d: got %h want %h", c, {req_rw_out, req_addr_out, req_data_out, req_byteen_out, req_tag_out}, held);
      end
      step();
    end
    req_ready_out = 1'b1;
    settle();
    total++;
    if (req_ready_in !== 4'b0001) begin bad++; $display("FAIL stall_refill: got %b want 0001", req_ready_in); end
    step();
  endtask

  task automatic test_same_cycle();
    int n;
    do_reset();
    req_valid_in[2] = 1'b1;
    req_ready_out   = 1'b1;
    for (int k = 0; k < 3; k++) step();
    rsp_valid_in  = 1'b1;
    rsp_tag_in    = {8'h33, 2'd2};
    rsp_ready_out = 4'b0100;
    settle();
    total++;
    if (req_ready_in !== 4'b0100 || rsp_valid_out !== 4'b0100) begin bad++; $display("FAIL same_cycle_hs: got rdy=%b rspv=%b want 0100/0100", req_ready_in, rsp_valid_out); end
    step();
    rsp_valid_in = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      settle();
      if (req_ready_in[2]) n++;
      step();
    end
    total++;
    if (n !== MP - 3) begin bad++; $display("FAIL same_cycle_count: got %0d further grants want %0d", n, MP - 3); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid_in[2] = 1'b1;
    step();
    req_valid_in = '1;
    settle();
    total++;
    if (req_valid_out !== 1'b1) begin bad++; $display("FAIL mid_full: got %b want 1", req_valid_out); end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (req_valid_out !== 1'b0 || req_ready_in !== 4'b0000) begin bad++; $display("FAIL mid_async: got v=%b rdy=%b want 0/0000", req_valid_out, req_ready_in); end
    #1;
    reset = 1'b0;
    req_ready_out = 1'b1;
    #1;
    total++;
    if (req_ready_in !== 4'b0001) begin bad++; $display("FAIL mid_first_grant: got %b want 0001", req_ready_in); end
    step();
    total++;
    if (req_valid_out !== 1'b1 || req_tag_out[1:0] !== 2'd0) begin bad++; $display("FAIL mid_out: got v=%b idx=%0d want 1/0", req_valid_out, req_tag_out[1:0]); end
  endtask

`ifdef DCACHE_PORT_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    req_valid_in[0] = 1'b1;
    req_ready_out   = 1'b1;
    for (int k = 0; k < MP + 10; k++) step();
    req_valid_in = '0;
    settle();
    total++;
    if (perf_stall_cycles !== 32'd10) begin bad++; $display("FAIL perf_stall: got %0d want 10", perf_stall_cycles); end
  endtask
`endif

  // Randomized traffic against a model built from the arbitration rules.
  task automatic test_random();
    int          mpend[N];
    int          m_last, g, r, idx;
    logic        m_full;
    logic [78:0] m_reg;
    logic [3:0]  e_rdy, e_rspv;
    do_reset();
    for (int i = 0; i < N; i++) mpend[i] = 0;
    m_last = N - 1;
    m_full = 1'b0;
    m_reg  = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid_in[i] && $urandom_range(0, 2) == 0) begin
          req_valid_in[i] = 1'b1;
          req_rw_in[i]    = ($urandom_range(0, 3) == 0);
          rand_payload(i);
        end
      end
      req_ready_out = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, N - 1);
      rsp_valid_in  = (mpend[r] > 0) && ($urandom_range(0, 1) == 1);
      rsp_tag_in    = {8'($urandom_range(0, 255)), 2'(r)};
      rsp_data_in   = $urandom;
      rsp_ready_out = 4'($urandom_range(0, 15));
      settle();

      g = -1;
      if (!m_full || req_ready_out) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (g < 0 && req_valid_in[idx] && (req_rw_in[idx] || mpend[idx] < MP)) g = idx;
        end
      end
      e_rdy  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      e_rspv = rsp_valid_in ? (4'b0001 << r) : 4'b0000;
      total++;
      if (req_ready_in !== e_rdy) begin bad++; $display("FAIL rand_grant c=%0d: got %b want %b", c, req_ready_in, e_rdy); end
      total++;
      if (req_valid_out !== m_full) begin bad++; $display("FAIL rand_valid c=%0d: got %b want %b", c, req_valid_out, m_full); end
      if (m_full) begin
        total++;
        if ({req_rw_out, req_addr_out, req_data_out, req_byteen_out, req_tag_out} !== m_reg) begin
          bad++; $display("FAIL rand_payload c=%0d: got %h want %h", c, {req_rw_out, req_addr_out, req_data_out, req_byteen_out, req_tag_out}, m_reg);
        end
      end
      total++;
      if (rsp_valid_out !== e_rspv || rsp_ready_in !== rsp_ready_out[r]) begin
        bad++; $display("FAIL rand_rsp c=%0d: got v=%b r=%b want v=%b r=%b", c, rsp_valid_out, rsp_ready_in, e_rspv, rsp_ready_out[r]);
      end

      if (rsp_valid_in && rsp_ready_out[r]) mpend[r]--;
      if (g >= 0) begin
        if (!req_rw_in[g]) mpend[g]++;
        m_reg  = {req_rw_in[g], req_addr_in[g], req_data_in[g], req_byteen_in[g], req_tag_in[g], 2'(g)};
        m_full = 1'b1;
        m_last = g;
      end else if (req_ready_out) begin
        m_full = 1'b0;
      end
      step();
      if (g >= 0) req_valid_in[g] = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_round_robin();
    test_pending_limit();
    test_stall();
    test_same_cycle();
    test_reset_mid();
`ifdef DCACHE_PORT_ARB_PERF_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_dcache_port_arb.md
VX_DCACHE_PORT_ARB -- requirements
Module: VX_dcache_port_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of requesters sharing one dcache request port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, word address width.
REQ-003 SHALL have parameter DATA_SIZE, default 4, bytes per word.
REQ-004 SHALL have parameter TAG_WIDTH, default 8, requester tag width.
REQ-005 SHALL have parameter MAX_PENDING, default 8, per-requester outstanding-read limit.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-008 SHALL have ports req_valid_in / req_ready_in, input / output, NUM_REQS each, per-requester handshake.
REQ-009 SHALL have ports req_rw_in, req_addr_in, req_data_in, req_byteen_in, req_tag_in, input, NUM_REQS x {1, ADDR_WIDTH, 8*DATA_SIZE, DATA_SIZE, TAG_WIDTH}, request payload (rw=1 store).
REQ-010 SHALL have ports req_valid_out / req_ready_out, output / input, 1 each, shared downstream handshake.
REQ-011 SHALL have ports req_rw_out, req_addr_out, req_data_out, req_byteen_out, output, payload of granted request.
REQ-012 SHALL have port req_tag_out, output, TAG_WIDTH+SEL_BITS, {requester tag, requester index}; SEL_BITS = max(1, clog2(NUM_REQS)).
REQ-013 SHALL have ports rsp_valid_in / rsp_ready_in, input / output, 1 each, plus rsp_data_in (8*DATA_SIZE) and rsp_tag_in (TAG_WIDTH+SEL_BITS).
REQ-014 SHALL have ports rsp_valid_out / rsp_ready_out, output / input, NUM_REQS each, plus rsp_data_out and rsp_tag_out (TAG_WIDTH) per requester.

Function
REQ-015 SHALL hold one output register with states EMPTY and FULL; EMPTY->FULL on grant, FULL->EMPTY on downstream fire with no new grant, FULL->FULL on fire with simultaneous grant.
REQ-016 SHALL grant only when state is EMPTY or req_ready_out is 1 (pipelined refill, 1-cycle request latency, full throughput).
REQ-017 SHALL arbitrate round-robin among eligible requesters, priority starting at last-granted index + 1, wrapping from NUM_REQS-1 to 0.
REQ-018 SHALL treat a requester as eligible when req_valid_in is 1 and, for reads, its pending count is below MAX_PENDING; stores always eligible.
REQ-019 SHALL assert req_ready_in only to the granted requester, in the grant cycle; payload captured into the output register on that edge.
REQ-020 SHALL keep the round-robin pointer unchanged in cycles with no grant.
REQ-021 SHALL increment a requester's pending count on its read grant and decrement on its response fire; simultaneous both leave it unchanged.
REQ-022 SHALL route responses combinationally by the index field of rsp_tag_in; rsp_ready_in = rsp_ready_out of the addressed requester; no response buffering.
REQ-023 SHALL treat out-of-range index (NUM_REQS not power of two) as dropped: rsp_ready_in=1, no rsp_valid_out, no count change.
REQ-024 SHALL not produce or expect responses for stores.
REQ-025 SHALL hold req_valid_out and payload stable while FULL and req_ready_out is 0.

Reset
REQ-026 SHALL on reset assertion immediately force state EMPTY, req_valid_out 0, all pending counts 0, round-robin pointer NUM_REQS-1 (requester 0 first).
REQ-027 SHALL drive req_ready_in 0 during reset; an in-flight request at reset is discarded.

Configuration
REQ-028 SHALL, with DCACHE_PORT_ARB_PERF_EN defined, add output perf_stall_cycles (PERF_CTR_BITS), counting cycles with any req_valid_in high and no grant, cleared by reset.
REQ-029 SHALL, without DCACHE_PORT_ARB_PERF_EN, omit that port and counter entirely.

Structure
REQ-030 SHALL place SEL_BITS computation helper and the arbiter state enum in VX_gpu_pkg.
REQ-031 SHALL implement round-robin selection as sub-module VX_rr_grant (request vector, enable -> one-hot grant, index).

Verification
REQ-032 SHALL test: NUM_REQS=4, all valid, reads, req_ready_out=1 -> grants 0,1,2,3,0 on consecutive cycles, req_tag_out low bits 0,1,2,3,0.
REQ-033 SHALL test: requester 1 issues 8 reads, no responses -> 9th read held, req_ready_in[1]=0; one response tag index 1 -> next cycle eligible again.
REQ-034 SHALL test: req_ready_out=0 for 5 cycles with FULL -> payload bits unchanged, no req_ready_in asserted.
REQ-035 SHALL test: requester 2 read grant and its response in same cycle with count 3 -> count stays 3.
REQ-036 SHALL test: reset asserted mid-cycle while FULL -> req_valid_out 0 before next clock edge, first post-reset grant to requester 0.
REQ-037 SHALL test: with DCACHE_PORT_ARB_PERF_EN, requester 0 blocked at MAX_PENDING for 10 cycles alone -> perf_stall_cycles = 10.
